// File: rtl/vga_frame_reader.sv
// vga_frame_reader: SDRAM-side producer for the VGA scan-out pixel FIFO.
// Fetches one frame of pixels in fixed-length read bursts and forwards each
// returned beat into the FIFO, restarting from BASE_ADDR on every frame start.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | after reset, waiting for the first frame_start
// S_SETTLE     | two-cycle hold so the FIFO fill level catches up
// S_WAIT_SPACE | waiting until the FIFO has room for a whole burst
// S_REQ        | burst request presented, waiting for rd_ack
// S_RECV       | forwarding the beats of an accepted burst
// S_DONE       | whole frame delivered, waiting for the next frame_start
module vga_frame_reader #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter logic [23:0] FRAME_WORDS = 24'd204800,
  parameter logic [3:0]  BURST_LEN   = 4'd8,
  parameter logic [7:0]  FILL_LEVEL  = 8'd224
) (
  input  logic        i_sdram_clk,
  input  logic        i_reset,
  input  logic        i_frame_start,
  input  logic [7:0]  i_wrusedw,
  output logic        o_rd_req,
  output logic [23:0] o_rd_addr,
  input  logic        i_rd_ack,
  input  logic        i_rd_valid,
  input  logic [15:0] i_rd_data,
  output logic        o_wr_fifo,
  output logic [15:0] o_sdram_data,
  output logic        o_frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_WAIT_SPACE, S_REQ, S_RECV, S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_settle_cnt;
  logic [3:0]  r_beat_cnt;
  logic [23:0] r_word_cnt;
  logic        r_restart_pending;
  logic [23:0] r_rd_addr;
  logic        r_wr_fifo;
  logic [15:0] r_sdram_data;
  logic        r_frame_done;

  logic        w_reload;
  logic        w_accept;
  logic        w_beat;
  logic        w_last_beat;
  logic        w_frame_end;
  logic        w_set_pending;
  logic [23:0] w_burst_words;
  logic [23:0] w_word_cnt_inc;

  assign w_burst_words  = {20'd0, BURST_LEN};
  assign w_word_cnt_inc = r_word_cnt + w_burst_words;

  // State register.
  always_ff @(posedge i_sdram_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode plus the single-cycle events that drive the datapath.
  always_comb begin
    w_state_nxt   = r_state;
    w_reload      = 1'b0;
    w_accept      = 1'b0;
    w_beat        = 1'b0;
    w_last_beat   = 1'b0;
    w_frame_end   = 1'b0;
    w_set_pending = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_frame_start) begin
          w_reload    = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (i_frame_start) begin
          w_reload    = 1'b1;
          w_state_nxt = S_SETTLE;
        end else if (r_settle_cnt) begin
          w_state_nxt = S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        if (i_frame_start) begin
          w_reload    = 1'b1;
          w_state_nxt = S_SETTLE;
        end else if (i_wrusedw < FILL_LEVEL) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        // A request already on the bus is never withdrawn; a restart waits.
        w_set_pending = i_frame_start;
        if (i_rd_ack) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RECV;
        end
      end
      S_RECV: begin
        w_beat        = i_rd_valid;
        w_last_beat   = i_rd_valid && (r_beat_cnt == BURST_LEN - 4'd1);
        // A frame_start on the final beat is consumed by this transition.
        w_set_pending = i_frame_start && !w_last_beat;
        if (w_last_beat) begin
          if (r_restart_pending || i_frame_start) begin
            w_reload    = 1'b1;
            w_state_nxt = S_SETTLE;
          end else if (w_word_cnt_inc == FRAME_WORDS) begin
            w_frame_end = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SETTLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: request straight from state, everything else from registers.
  always_comb begin
    o_rd_req     = (r_state == S_REQ);
    o_rd_addr    = r_rd_addr;
    o_wr_fifo    = r_wr_fifo;
    o_sdram_data = r_sdram_data;
    o_frame_done = r_frame_done;
  end

  // Counters, burst address, restart flag and the registered FIFO write port.
  always_ff @(posedge i_sdram_clk) begin
    if (i_reset) begin
      r_settle_cnt      <= 1'b0;
      r_beat_cnt        <= 4'd0;
      r_word_cnt        <= 24'd0;
      r_restart_pending <= 1'b0;
      r_rd_addr         <= BASE_ADDR;
      r_wr_fifo         <= 1'b0;
      r_sdram_data      <= 16'd0;
      r_frame_done      <= 1'b0;
    end else begin
      r_settle_cnt <= (r_state == S_SETTLE) && !w_reload && !r_settle_cnt;

      if (w_reload) begin
        r_rd_addr  <= BASE_ADDR;
        r_word_cnt <= 24'd0;
      end else begin
        if (w_accept) begin
          r_rd_addr <= r_rd_addr + w_burst_words;
        end
        if (w_last_beat) begin
          r_word_cnt <= w_word_cnt_inc;
        end
      end

      if (w_reload) begin
        r_restart_pending <= 1'b0;
      end else if (w_set_pending) begin
        r_restart_pending <= 1'b1;
      end

      if (w_accept) begin
        r_beat_cnt <= 4'd0;
      end else if (w_beat) begin
        r_beat_cnt <= r_beat_cnt + 4'd1;
      end

      r_wr_fifo <= w_beat;
      if (w_beat) begin
        r_sdram_data <= i_rd_data;
      end
      r_frame_done <= w_frame_end;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Testbench for vga_frame_reader: acts as SDRAM controller and FIFO, and checks
// the DUT against a transaction-level model of bursts and frames.
module tb_vga_frame_reader;

  localparam logic [23:0] BASE  = 24'h000000;
  localparam int          FRAME = 32;
  localparam int          BURST = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [7:0]  wrusedw;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_ack;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        wr_fifo;
  logic [15:0] sdram_data;
  logic        frame_done;

  vga_frame_reader #(
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(24'd32),
    .BURST_LEN  (4'd8),
    .FILL_LEVEL (8'd224)
  ) dut (
    .i_sdram_clk  (clk),
    .i_reset      (reset),
    .i_frame_start(frame_start),
    .i_wrusedw    (wrusedw),
    .o_rd_req     (rd_req),
    .o_rd_addr    (rd_addr),
    .i_rd_ack     (rd_ack),
    .i_rd_valid   (rd_valid),
    .i_rd_data    (rd_data),
    .o_wr_fifo    (wr_fifo),
    .o_sdram_data (sdram_data),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_wr = 0;
  int n_done = 0;

  // reference model state
  bit          m_win = 0;
  int          m_beats = 0;
  bit          m_pend = 0;
  int          m_words = 0;
  logic [23:0] m_next = BASE;
  bit          m_allowed = 0;
  bit          exp_wr = 0;
  bit          exp_done = 0;
  logic [15:0] exp_data = 16'd0;

  typedef struct {
    logic [7:0] used;
    int         cyc;
    logic       exp_req;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: check the previous edge's outputs, advance the model for the
  // coming edge, then return just after that edge.
  task automatic tick();
    bit done_now;
    @(negedge clk);
    if (exp_wr || wr_fifo) begin
      chk("wr_fifo", {31'd0, wr_fifo}, {31'd0, exp_wr});
      if (exp_wr) chk("sdram_data", {16'd0, sdram_data}, {16'd0, exp_data});
    end
    if (exp_done || frame_done)
      chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
    if (wr_fifo) n_wr++;
    if (frame_done) n_done++;
    if (!m_allowed) chk("rd_req_blocked", {31'd0, rd_req}, 32'd0);

    if (reset) begin
      m_win = 0; m_beats = 0; m_pend = 0; m_words = 0;
      m_next = BASE; m_allowed = 0; exp_wr = 0; exp_done = 0;
    end else begin
      done_now = 0;
      exp_done = 0;
      exp_wr   = m_win && rd_valid;
      exp_data = rd_data;
      if (m_win && rd_valid) begin
        m_beats++;
        if (m_beats == BURST) begin
          m_win = 0;
          done_now = 1;
          if (m_pend || frame_start) begin
            m_pend = 0; m_words = 0; m_next = BASE; m_allowed = 1;
          end else begin
            m_words += BURST;
            if (m_words == FRAME) begin
              exp_done = 1;
              m_allowed = 0;
            end
          end
        end
      end
      if (frame_start && !done_now) begin
        if (m_win || rd_req) m_pend = 1;
        else begin
          m_next = BASE; m_words = 0; m_pend = 0; m_allowed = 1;
        end
      end
      if (rd_req && rd_ack) begin
        chk("req_addr", {8'd0, rd_addr}, {8'd0, m_next});
        m_next = m_next + 24'd8;
        m_win = 1;
        m_beats = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; frame_start = 0; rd_ack = 0; rd_valid = 0; rd_data = 16'd0; wrusedw = 8'd0;
    tick();
    tick();
    reset = 0;
  endtask

  task automatic pulse_fs();
    frame_start = 1;
    tick();
    frame_start = 0;
  endtask

  task automatic start_burst(input bit stray, output bit ok);
    int n;
    n = 0;
    rd_ack = 1;
    while (!rd_req && n < 60) begin
      rd_valid = stray ? ($urandom_range(0, 1) == 1) : 1'b0;
      rd_data  = 16'($urandom);
      tick();
      n++;
    end
    rd_valid = 0;
    ok = rd_req;
    if (!ok) chk("req_timeout", {31'd0, rd_req}, 32'd1);
    else tick();
    rd_ack = 0;
  endtask

  // fs_mode: -1 none, 0..7 frame_start on a gap after that many beats,
  // 8 frame_start coincident with the final beat.
  task automatic send_beats(input int n, input int max_gap, input int fs_mode);
    for (int b = 0; b < n; b++) begin
      if (fs_mode == b) begin
        frame_start = 1; rd_valid = 0;
        tick();
        frame_start = 0;
      end
      repeat ($urandom_range(0, max_gap)) begin
        rd_valid = 0;
        tick();
      end
      rd_valid = 1;
      rd_data = 16'($urandom);
      frame_start = (fs_mode == 8 && b == 7);
      tick();
      frame_start = 0;
    end
    rd_valid = 0;
  endtask

  task automatic run_burst(input int max_gap, input bit stray, input int fs_mode);
    bit ok;
    start_burst(stray, ok);
    send_beats(BURST, max_gap, fs_mode);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, d0;
    bit ok;
    vecs[0] = '{8'd0,   2, 1'b0};
    vecs[1] = '{8'd0,   3, 1'b1};
    vecs[2] = '{8'd223, 3, 1'b1};
    vecs[3] = '{8'd224, 3, 1'b0};
    vecs[4] = '{8'd224, 8, 1'b0};
    vecs[5] = '{8'd225, 6, 1'b0};
    vecs[6] = '{8'd255, 6, 1'b0};
    vecs[7] = '{8'd100, 5, 1'b1};

    // reset state
    do_reset();
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_rd_addr", {8'd0, rd_addr}, {8'd0, BASE});
    chk("rst_wr_fifo", {31'd0, wr_fifo}, 32'd0);
    chk("rst_data", {16'd0, sdram_data}, 32'd0);
    chk("rst_done", {31'd0, frame_done}, 32'd0);

    // fill level threshold and request latency
    for (int i = 0; i < 8; i++) begin
      do_reset();
      wrusedw = vecs[i].used;
      pulse_fs();
      repeat (vecs[i].cyc) tick();
      chk($sformatf("req_vec%0d", i), {31'd0, rd_req}, {31'd0, vecs[i].exp_req});
    end

    // held at the threshold, then released
    do_reset();
    wrusedw = 8'd224;
    pulse_fs();
    repeat (12) tick();
    chk("req_full", {31'd0, rd_req}, 32'd0);
    wrusedw = 8'd223;
    tick();
    chk("req_space", {31'd0, rd_req}, 32'd1);

    // first burst, ack in the first request cycle, gapless beats
    do_reset();
    n0 = n_wr;
    rd_ack = 1;
    pulse_fs();
    tick();
    chk("req_c1", {31'd0, rd_req}, 32'd0);
    tick();
    chk("req_c2", {31'd0, rd_req}, 32'd0);
    tick();
    chk("req_c3", {31'd0, rd_req}, 32'd1);
    chk("first_addr", {8'd0, rd_addr}, {8'd0, BASE});
    tick();
    rd_ack = 0;
    chk("req_drop", {31'd0, rd_req}, 32'd0);
    send_beats(BURST, 0, -1);
    tick();
    tick();
    chk("burst1_wr", n_wr - n0, 32'd8);
    chk("next_addr", {8'd0, rd_addr}, {8'd0, BASE + 24'd8});

    // rest of the small frame
    d0 = n_done;
    repeat (3) run_burst(0, 0, -1);
    tick();
    chk("frame_wr", n_wr - n0, 32'd32);
    chk("frame_done_cnt", n_done - d0, 32'd1);
    repeat (30) tick();
    chk("frame_idle", {31'd0, rd_req}, 32'd0);

    // restart during RECV after 3 beats
    d0 = n_done;
    n0 = n_wr;
    pulse_fs();
    run_burst(0, 0, 3);
    chk("restart_wr", n_wr - n0, 32'd8);
    repeat (3) run_burst(1, 0, -1);
    tick();
    chk("restart_no_done", n_done - d0, 32'd0);
    run_burst(1, 0, -1);
    tick();
    chk("restart_done", n_done - d0, 32'd1);

    // restart coincident with the final beat
    d0 = n_done;
    pulse_fs();
    run_burst(2, 0, 8);
    run_burst(0, 0, -1);
    chk("last_beat_restart", {8'd0, rd_addr}, {8'd0, BASE + 24'd8});
    repeat (3) run_burst(0, 0, -1);
    tick();
    chk("last_beat_done", n_done - d0, 32'd1);

    // random gaps and stray beats outside bursts
    d0 = n_done;
    wrusedw = 8'd224;
    pulse_fs();
    repeat (10) begin
      rd_valid = ($urandom_range(0, 1) == 1);
      rd_data = 16'($urandom);
      tick();
    end
    rd_valid = 0;
    wrusedw = 8'd0;
    n0 = n_wr;
    repeat (4) run_burst(3, 1, -1);
    tick();
    chk("gap_wr", n_wr - n0, 32'd32);
    chk("gap_done", n_done - d0, 32'd1);

    // reset in the middle of RECV
    pulse_fs();
    n0 = n_wr;
    start_burst(0, ok);
    send_beats(3, 0, -1);
    reset = 1;
    rd_valid = 1;
    tick();
    chk("mid_rst_req", {31'd0, rd_req}, 32'd0);
    chk("mid_rst_wr", {31'd0, wr_fifo}, 32'd0);
    chk("mid_rst_addr", {8'd0, rd_addr}, {8'd0, BASE});
    reset = 0;
    repeat (5) begin
      rd_data = 16'($urandom);
      tick();
    end
    rd_valid = 0;
    repeat (20) tick();
    chk("mid_rst_beats", n_wr - n0, 32'd3);
    chk("mid_rst_idle", {31'd0, rd_req}, 32'd0);

    // randomized run against the model
    do_reset();
    d0 = n_done;
    for (int c = 0; c < 4000; c++) begin
      frame_start = (c == 0) || ($urandom_range(0, 149) == 0);
      wrusedw = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                            : 8'($urandom_range(0, 223));
      rd_ack = ($urandom_range(0, 2) == 0);
      rd_valid = m_win ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 5) == 0);
      rd_data = 16'($urandom);
      tick();
    end
    frame_start = 0; rd_valid = 0; rd_ack = 0;
    tick();
    tick();
    chk("random_frames", {31'd0, (n_done > d0)}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
